// File: rtl/c432_key_loader.sv
// Key loader for the locked c432 core: assembles a 13-word frame into a shadow
// register, verifies padding and XOR checksum, and only then exposes the key.
module c432_key_loader #(
  parameter int KEY_X_W = 88,
  parameter int KEY_P_W = 4,
  parameter int WORD_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic [KEY_X_W-1:0] key_x,
  output logic [KEY_P_W-1:0] key_p,
  output logic               key_valid,
  output logic               busy,
  output logic               error
);
  localparam int KEY_W     = KEY_X_W + KEY_P_W;
  localparam int NWORDS    = (KEY_W + WORD_W - 1) / WORD_W;
  localparam int LAST      = NWORDS - 1;
  localparam int LAST_BITS = KEY_W - LAST * WORD_W;
  localparam int CNT_W     = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  csum_q, csum_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic               pad_err_q, pad_err_d;
  logic [KEY_X_W-1:0] key_x_q, key_x_d;
  logic [KEY_P_W-1:0] key_p_q, key_p_d;
  logic               key_valid_q, key_valid_d;
  logic               error_q, error_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    shadow_d    = shadow_q;
    pad_err_d   = pad_err_q;
    key_x_d     = key_x_q;
    key_p_d     = key_p_q;
    key_valid_d = key_valid_q;
    error_d     = error_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          // Drop any previous key before the reload begins.
          state_d     = S_LOAD;
          cnt_d       = '0;
          csum_d      = '0;
          shadow_d    = '0;
          pad_err_d   = 1'b0;
          key_x_d     = '0;
          key_p_d     = '0;
          key_valid_d = 1'b0;
          error_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (start) begin
          cnt_d     = '0;
          csum_d    = '0;
          shadow_d  = '0;
          pad_err_d = 1'b0;
        end else if (xfer) begin
          if (cnt_q == CNT_W'(NWORDS)) begin
            if (in_data == csum_q && !pad_err_q) begin
              state_d     = S_DONE;
              key_x_d     = shadow_q[KEY_X_W-1:0];
              key_p_d     = shadow_q[KEY_W-1:KEY_X_W];
              key_valid_d = 1'b1;
            end else begin
              state_d = S_ERR;
              error_d = 1'b1;
            end
          end else begin
            for (int i = 0; i < LAST; i++)
              if (cnt_q == CNT_W'(i)) shadow_d[i*WORD_W +: WORD_W] = in_data;
            if (cnt_q == CNT_W'(LAST)) begin
              shadow_d[KEY_W-1 -: LAST_BITS] = in_data[LAST_BITS-1:0];
              pad_err_d = |in_data[WORD_W-1:LAST_BITS];
            end
            csum_d = csum_q ^ in_data;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
    endcase
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      csum_q      <= '0;
      shadow_q    <= '0;
      pad_err_q   <= 1'b0;
      key_x_q     <= '0;
      key_p_q     <= '0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      shadow_q    <= shadow_d;
      pad_err_q   <= pad_err_d;
      key_x_q     <= key_x_d;
      key_p_q     <= key_p_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign key_x     = key_x_q;
  assign key_p     = key_p_q;
  assign key_valid = key_valid_q;
  assign error     = error_q;
endmodule

// File: tb/tb_c432_key_loader.sv
// Bench for c432_key_loader: frame-level reference model compared every cycle,
// plus hand-computed expectations for the directed frames.
module tb_c432_key_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, key_valid, busy, error;
  logic [87:0] key_x;
  logic [3:0]  key_p;

  c432_key_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .key_x(key_x), .key_p(key_p), .key_valid(key_valid),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: collects accepted words of the current frame and decides
  // the outcome once 13 have arrived.
  logic [7:0]  mq[$];
  bit          m_loading;
  logic [87:0] m_kx;
  logic [3:0]  m_kp;
  bit          m_kv, m_err;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] x, w11;
    if (!rst_n || start) begin
      m_loading = rst_n;
      mq.delete();
      m_kx = '0; m_kp = '0; m_kv = 0; m_err = 0;
    end else if (m_loading && in_valid) begin
      mq.push_back(in_data);
      if (mq.size() == 13) begin
        x = 8'h00;
        for (int i = 0; i < 12; i++) x ^= mq[i];
        w11 = mq[11];
        m_loading = 0;
        if (x == mq[12] && w11[7:4] == 4'h0) begin
          for (int i = 0; i < 11; i++) m_kx[8*i +: 8] = mq[i];
          m_kp = w11[3:0];
          m_kv = 1;
        end else m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready", {87'd0, in_ready}, {87'd0, m_loading});
      check("busy", {87'd0, busy}, {87'd0, m_loading});
      check("key_valid", {87'd0, key_valid}, {87'd0, m_kv});
      check("error", {87'd0, error}, {87'd0, m_err});
      check("key_x", key_x, m_kx);
      check("key_p", {84'd0, key_p}, {84'd0, m_kp});
    end
  end

  task automatic do_start();
    start = 1'b1; in_valid = 1'($urandom); in_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input int gap);
    repeat (gap) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between words, 2: random gaps
  task automatic send_words(input logic [7:0] fr [13], input int n, input int mode);
    for (int i = 0; i < n; i++)
      send(fr[i], (mode == 0 || i == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3)));
  endtask

  task automatic mk_frame(output logic [7:0] fr [13]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin
      fr[i] = 8'($urandom);
      if (i == 11) fr[i][7:4] = 4'h0;
      x ^= fr[i];
    end
    fr[12] = x;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {87'd0, in_ready}, 88'd0);
    check({tag, "_busy"}, {87'd0, busy}, 88'd0);
    check({tag, "_key_valid"}, {87'd0, key_valid}, 88'd0);
    check({tag, "_error"}, {87'd0, error}, 88'd0);
    check({tag, "_key_x"}, key_x, 88'd0);
    check({tag, "_key_p"}, {84'd0, key_p}, 88'd0);
  endtask

  logic [7:0] ff_fr [13];
  logic [7:0] fr [13];

  initial begin
    for (int i = 0; i < 11; i++) ff_fr[i] = 8'hFF;
    ff_fr[11] = 8'h0F; ff_fr[12] = 8'hF0;

    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    // All-ones key, back-to-back; key_valid low just before the checksum edge.
    do_start();
    send_words(ff_fr, 12, 0);
    check("t1_pre_commit_kv", {87'd0, key_valid}, 88'd0);
    send(ff_fr[12], 0);
    check("t1_kv", {87'd0, key_valid}, 88'd1);
    check("t1_key_x", key_x, {88{1'b1}});
    check("t1_key_p", {84'd0, key_p}, 88'hF);
    check("t1_err", {87'd0, error}, 88'd0);
    check("t1_ready_drop", {87'd0, in_ready}, 88'd0);

    // Bad checksum, then recovery.
    fr = ff_fr; fr[12] = 8'hF1;
    do_start(); send_words(fr, 13, 0);
    check("t2_err", {87'd0, error}, 88'd1);
    check("t2_kv", {87'd0, key_valid}, 88'd0);
    check("t2_key_x", key_x, 88'd0);
    check("t2_key_p", {84'd0, key_p}, 88'd0);
    do_start(); send_words(ff_fr, 13, 2);
    check("t2_recover_kv", {87'd0, key_valid}, 88'd1);
    check("t2_recover_err", {87'd0, error}, 88'd0);

    // Padding bit set with a consistent checksum.
    fr = ff_fr; fr[11] = 8'h1F; fr[12] = 8'hE0;
    do_start(); send_words(fr, 13, 0);
    check("t3_pad_err", {87'd0, error}, 88'd1);
    check("t3_pad_kv", {87'd0, key_valid}, 88'd0);

    // Word i = i; XOR of 0x00..0x0B is 0x00; in_valid toggled.
    for (int i = 0; i < 12; i++) fr[i] = 8'(i);
    fr[12] = 8'h00;
    do_start(); send_words(fr, 13, 1);
    check("t4_kv", {87'd0, key_valid}, 88'd1);
    check("t4_key_x_15_8", {80'd0, key_x[15:8]}, 88'h01);
    check("t4_key_x_87_80", {80'd0, key_x[87:80]}, 88'h0A);
    check("t4_key_p", {84'd0, key_p}, 88'hB);

    // Asynchronous reset mid-frame.
    do_start(); send_words(ff_fr, 7, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    do_start(); send_words(ff_fr, 13, 0);
    check("t5_kv", {87'd0, key_valid}, 88'd1);

    // Reload from DONE with a different key.
    mk_frame(fr);
    do_start();
    check("t6_stale_kv", {87'd0, key_valid}, 88'd0);
    check("t6_stale_kx", key_x, 88'd0);
    send_words(fr, 13, 2);
    check("t6_kv", {87'd0, key_valid}, 88'd1);
    check("t6_kx_lo", {80'd0, key_x[7:0]}, {80'd0, fr[0]});
    check("t6_kp", {84'd0, key_p}, {84'd0, fr[11][3:0]});

    // Random frames with corruption, restarts and gaps.
    for (int it = 0; it < 40; it++) begin
      mk_frame(fr);
      case ($urandom_range(0, 5))
        0: fr[12] ^= 8'(1 << $urandom_range(0, 7));
        1: fr[11][7:4] = 4'($urandom_range(1, 15));
        default: ;
      endcase
      do_start();
      if ($urandom_range(0, 3) == 0) begin
        send_words(fr, int'($urandom_range(1, 12)), 2);
        do_start();
      end
      send_words(fr, 13, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
